// File: rtl/ram_loader.sv
// UART-fed RAM loader: receives a 16-bit little-endian word count followed by
// that many little-endian 32-bit words and writes them to consecutive RAM addresses.
module ram_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        start,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] MAX_W   = 32'(MAX_WORDS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LEN_LO = 2'd1;
    localparam logic [1:0] ST_LEN_HI = 2'd2;
    localparam logic [1:0] ST_DATA   = 2'd3;

    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]  r_rx_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_byte_valid, r_frame_err;

    logic [1:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_word_cnt;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word_buf;
    logic        r_we, r_busy, r_done, r_err;
    logic [31:0] r_addr, r_wd;

    logic [15:0] w_len;
    logic        w_len_bad;

    assign w_len     = {r_shift, r_len[7:0]};
    assign w_len_bad = (w_len == 16'd0) || ({16'd0, w_len} > MAX_W);

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // 8N1 receiver; runs regardless of loader state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= 16'd0;
                    r_bit_idx <= 3'd0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_M1) begin
                        r_clk_cnt  <= 16'd0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= 16'd0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt    <= 16'd0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader FSM: length header, word assembly and write issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word_buf <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wd       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LEN_LO;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_word_cnt <= 16'd0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                ST_LEN_LO: begin
                    if (r_frame_err) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_byte_valid) begin
                        r_len[7:0] <= r_shift;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (r_frame_err || (r_byte_valid && w_len_bad)) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_byte_valid) begin
                        r_len   <= w_len;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_frame_err) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_byte_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word_buf[7:0]   <= r_shift;
                            2'd1: r_word_buf[15:8]  <= r_shift;
                            2'd2: r_word_buf[23:16] <= r_shift;
                            default: begin
                                r_we       <= 1'b1;
                                r_wd       <= {r_shift, r_word_buf};
                                r_addr     <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
                                r_word_cnt <= r_word_cnt + 16'd1;
                                // Final word: completion is visible in the same cycle as the strobe
                                if (r_word_cnt == r_len - 16'd1) begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign we   = r_we;
    assign addr = r_addr;
    assign wd   = r_wd;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: UART byte streams in, RAM writes compared
// against a list-based model of the length/word protocol.
module tb_ram_loader;

    localparam int          CLKS = 52;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst_n, rxd, start;
    logic        we, busy, done, err;
    logic [31:0] addr, wd;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_wd[$];
    logic        q_busy[$];
    logic        q_done[$];
    int          consec = 0;
    int          bv_cnt = 0;
    logic        prev_we = 1'b0;

    ram_loader #(.CLKS_PER_BIT(CLKS), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .start(start),
        .we(we), .addr(addr), .wd(wd), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Capture every write strobe, mid-cycle, together with the status flags
    always @(negedge clk) begin
        if (we) begin
            q_addr.push_back(addr);
            q_wd.push_back(wd);
            q_busy.push_back(busy);
            q_done.push_back(done);
            if (prev_we) consec <= consec + 1;
        end
        prev_we <= we;
        if (dut.r_byte_valid) bv_cnt <= bv_cnt + 1;
    end

    task automatic clear_caps();
        q_addr.delete(); q_wd.delete(); q_busy.delete(); q_done.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rxd = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rxd = stop_val;
        repeat (CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        checks += 6;
        if (we !== 1'b0)   begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        if (addr !== BASE) begin errors++; $display("FAIL reset_addr: got %h expected %h", addr, BASE); end
        if (wd !== 32'd0)  begin errors++; $display("FAIL reset_wd: got %h expected 0", wd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    // Stream a complete load and compare writes with the expected word list
    task automatic run_good_load(input string name, input logic [7:0] bytes[$]);
        int n;
        logic [31:0] exp_wd;
        n = int'({bytes[1], bytes[0]});
        clear_caps();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_set: got %b expected 1", name, busy); end
        foreach (bytes[k]) send_byte(bytes[k], 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (q_addr.size() !== n) begin
            errors++; $display("FAIL %s_count: got %0d expected %0d", name, q_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_wd = {bytes[2+4*i+3], bytes[2+4*i+2], bytes[2+4*i+1], bytes[2+4*i]};
                checks += 3;
                if (q_addr[i] !== BASE + 32'(4*i)) begin errors++; $display("FAIL %s_addr%0d: got %h expected %h", name, i, q_addr[i], BASE + 32'(4*i)); end
                if (q_wd[i] !== exp_wd) begin errors++; $display("FAIL %s_wd%0d: got %h expected %h", name, i, q_wd[i], exp_wd); end
                if ({q_busy[i], q_done[i]} !== ((i == n-1) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL %s_flags%0d: got busy/done %b%b", name, i, q_busy[i], q_done[i]);
                end
            end
        end
        checks++;
        if ({busy, done, err} !== 3'b010) begin errors++; $display("FAIL %s_status: got busy/done/err %b%b%b expected 010", name, busy, done, err); end
    endtask

    task automatic test_normal_load();
        logic [7:0] b[$] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_good_load("normal", b);
    endtask

    task automatic test_bad_length(input string name, input logic [7:0] lo, input logic [7:0] hi);
        clear_caps();
        pulse_start();
        send_byte(lo, 1'b1);
        send_byte(hi, 1'b1);
        repeat (10) @(negedge clk);
        checks += 2;
        if (q_addr.size() !== 0) begin errors++; $display("FAIL %s_writes: got %0d expected 0", name, q_addr.size()); end
        if ({busy, done, err} !== 3'b001) begin errors++; $display("FAIL %s_status: got busy/done/err %b%b%b expected 001", name, busy, done, err); end
    endtask

    task automatic test_framing();
        clear_caps();
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        repeat (CLKS) @(negedge clk);
        checks += 2;
        if (q_addr.size() !== 0) begin errors++; $display("FAIL framing_writes: got %0d expected 0", q_addr.size()); end
        if ({busy, done, err} !== 3'b001) begin errors++; $display("FAIL framing_status: got busy/done/err %b%b%b expected 001", busy, done, err); end
    endtask

    task automatic test_glitch_and_ignored();
        int bv0;
        logic [7:0] w[4];
        bv0 = bv_cnt;
        @(negedge clk) rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        checks++;
        if (bv_cnt !== bv0) begin errors++; $display("FAIL glitch_bytevalid: got %0d expected %0d", bv_cnt, bv0); end
        clear_caps();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        checks += 2;
        if (q_addr.size() !== 0) begin errors++; $display("FAIL prestart_writes: got %0d expected 0", q_addr.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL prestart_busy: got %b expected 0", busy); end
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(w[0], 1'b1); send_byte(w[1], 1'b1);
        pulse_start();
        send_byte(w[2], 1'b1); send_byte(w[3], 1'b1);
        repeat (10) @(negedge clk);
        checks += 3;
        if (q_addr.size() !== 1) begin
            errors++; $display("FAIL restart_count: got %0d expected 1", q_addr.size());
        end else if (q_wd[0] !== {w[3], w[2], w[1], w[0]} || q_addr[0] !== BASE) begin
            errors++; $display("FAIL restart_word: got %h@%h expected %h@%h", q_wd[0], q_addr[0], {w[3], w[2], w[1], w[0]}, BASE);
        end
        if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", done); end
    endtask

    task automatic test_random_loads();
        logic [7:0] b[$];
        int n;
        for (int it = 0; it < 3; it++) begin
            n = int'($urandom_range(1, 3));
            b.delete();
            b.push_back(8'(n)); b.push_back(8'h00);
            for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
            run_good_load($sformatf("rand%0d", it), b);
        end
    endtask

    task automatic test_reset_midload();
        clear_caps();
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        checks += 2;
        if (q_addr.size() !== 0) begin errors++; $display("FAIL midreset_writes: got %0d expected 0", q_addr.size()); end
        if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midreset_status: got busy/done/err %b%b%b expected 000", busy, done, err); end
    endtask

    initial begin
        rst_n = 1'b0; rxd = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_normal_load();
        test_bad_length("zero_len", 8'h00, 8'h00);
        test_bad_length("oversize", 8'h01, 8'h01);
        test_framing();
        test_glitch_and_ignored();
        test_random_loads();
        test_reset_midload();
        checks++;
        if (consec !== 0) begin errors++; $display("FAIL we_consecutive: got %0d expected 0", consec); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
